jk_excite_drv: RTL and testbench
================================

JK_EXCITE_DRV -- requirements
Module: jk_excite_drv

Interface
REQ-001 Parameter: DEPTH, default 4, input FIFO depth in bits; legal values are powers of two, 2 to 16.
REQ-002 Parameter: TOGGLE_STYLE, default 0; 0 = set/reset excitation, 1 = toggle excitation.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port in_valid  input  1  in_bit holds a target Q value.
REQ-006 Port in_ready  output  1  FIFO can accept a bit; equals !full.
REQ-007 Port in_bit  input  1  desired next Q of the downstream JK flip-flop.
REQ-008 Port J  output  1  registered J drive to the flip-flop.
REQ-009 Port K  output  1  registered K drive to the flip-flop.
REQ-010 Port q_fb  input  1  Q fed back from the driven flip-flop.
REQ-011 Port busy  output  1  FIFO non-empty or a check pending.
REQ-012 Port err_clr  input  1  synchronous clear of err (present only with the macro).
REQ-013 Port err  output  1  sticky feedback mismatch flag (present only with the macro).

Function
REQ-014 A push SHALL occur on an edge where in_valid && in_ready; a push SHALL be blocked when full, even if a pop occurs on the same edge.
REQ-015 A pop SHALL occur on every edge where the FIFO is non-empty, so the block issues one bit per cycle.
REQ-016 There SHALL be no bypass: a bit pushed at edge n is popped no earlier than edge n+1, and its J/K appear after edge n+1.
REQ-017 Register q_exp SHALL track the flip-flop state; on a pop it SHALL load the popped bit b, and J/K SHALL be computed from the old q_exp and b.
REQ-018 With TOGGLE_STYLE=0, the encoding SHALL be: q_exp==b -> J=0, K=0; 0->1 -> J=1, K=0; 1->0 -> J=0, K=1.
REQ-019 With TOGGLE_STYLE=1, the encoding SHALL be: q_exp==b -> J=0, K=0; q_exp!=b -> J=1, K=1.
REQ-020 On an edge with no pop, J and K SHALL be driven to 0 (hold).
REQ-021 FIFO pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; occupancy SHALL be log2(DEPTH)+1 bits wide.
REQ-022 busy SHALL be 1 whenever occupancy>0 or any check stage is valid.

Reset
REQ-023 On rst_n low, asynchronously: J=0, K=0, q_exp=0, FIFO empty, in_ready=1, busy=0, check pipeline invalid, err=0.
REQ-024 Reset mid-stream SHALL discard all queued bits and pending checks; the first bit after release is encoded against q_exp=0.

Configuration
REQ-025 Macro JK_EXCITE_DRV_CHECK_EN SHALL gate the feedback check.
REQ-026 With the macro defined: the bit issued at edge n is compared with q_fb sampled at edge n+2; a mismatch sets err, which holds until err_clr or reset; err_clr wins over a simultaneous mismatch.
REQ-027 Without the macro: err and err_clr are absent, q_fb is unused, no check pipeline exists, and busy reflects FIFO occupancy only.

Structure
REQ-028 Package jk_pkg SHALL hold the jk_enc_t struct {j,k}, the encode function and the style constants JK_STYLE_SR=0 and JK_STYLE_TGL=1.
REQ-029 Sub-module jk_bit_fifo (DEPTH parameter; push/pop/full/empty ports) SHALL implement the buffer; the remaining logic lives in the top level.

Verification
REQ-030 Style 0, push 1,1,0 on consecutive edges from reset -> after successive pops J/K = 10, 00, 01, followed by 00.
REQ-031 Style 1, push 1,0,0,1 -> J/K = 11, 11, 00, 11.
REQ-032 DEPTH=4, in_valid held high while pops are stalled by reset timing -> in_ready=0 at 4 entries; a push on a full edge is dropped; bit order is preserved across pointer wrap after 9 bits.
REQ-033 Assert rst_n low with 3 bits queued -> J=K=0, busy=0 immediately; the next push of 1 gives J/K=10.
REQ-034 With the macro, a testbench JK flip-flop on J/K/q_fb with no faults -> err stays 0 over 100 random bits.
REQ-035 With the macro, force q_fb=0 while issuing 1 -> err=1 two edges later; err_clr clears it the next edge.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and the J/K excitation encoder for the JK flip-flop driver.
package jk_pkg;

  localparam int JK_STYLE_SR  = 0;
  localparam int JK_STYLE_TGL = 1;

  typedef struct packed {
    logic j;
    logic k;
  } jk_enc_t;

  // Excitation needed to move a JK flip-flop from state q to target b.
  function automatic jk_enc_t jk_encode(input logic q, input logic b, input int style);
    jk_enc_t e;
    e = '{j: 1'b0, k: 1'b0};
    if (q != b) begin
      if (style == JK_STYLE_TGL) begin
        e = '{j: 1'b1, k: 1'b1};
      end else begin
        e.j = b;
        e.k = q;
      end
    end
    return e;
  endfunction

endpackage

// File: rtl/jk_bit_fifo.sv
// Single-bit-wide FIFO of DEPTH entries (power of two); push is refused when full.
module jk_bit_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push_ok, pop_ok;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: storage carries no reset; the occupancy count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jk_excite_drv.sv
// Converts a stream of target Q bits into registered J/K drive for a JK flip-flop.
// Optional feedback check of q_fb against issued bits: define JK_EXCITE_DRV_CHECK_EN.
module jk_excite_drv
  import jk_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int TOGGLE_STYLE = JK_STYLE_SR
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  output logic J,
  output logic K,
  input  logic q_fb,
`ifdef JK_EXCITE_DRV_CHECK_EN
  input  logic err_clr,
  output logic err,
`endif
  output logic busy
);

  logic    fifo_full, fifo_empty, fifo_dout;
  logic    pop;
  logic    q_exp;
  jk_enc_t enc;

  assign in_ready = !fifo_full;
  assign pop      = !fifo_empty;

  jk_bit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid && in_ready),
    .pop   (pop),
    .din   (in_bit),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb enc = jk_encode(q_exp, fifo_dout, TOGGLE_STYLE);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      J     <= 1'b0;
      K     <= 1'b0;
      q_exp <= 1'b0;
    end else if (pop) begin
      J     <= enc.j;
      K     <= enc.k;
      q_exp <= fifo_dout;
    end else begin
      J     <= 1'b0;
      K     <= 1'b0;
    end
  end

`ifdef JK_EXCITE_DRV_CHECK_EN
  // Stage 0 holds the bit issued last edge; stage 1 meets the flip-flop's settled Q.
  logic [1:0] chk_vld;
  logic [1:0] chk_bit;
  logic       mismatch;

  assign mismatch = chk_vld[1] && (q_fb != chk_bit[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_vld <= '0;
      chk_bit <= '0;
      err     <= 1'b0;
    end else begin
      chk_vld <= {chk_vld[0], pop};
      chk_bit <= {chk_bit[0], fifo_dout};
      if (err_clr)       err <= 1'b0;
      else if (mismatch) err <= 1'b1;
    end
  end

  assign busy = !fifo_empty || (|chk_vld);
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign busy        = !fifo_empty;
`endif

endmodule

// File: tb/tb_jk_excite_drv.sv
// Self-checking bench: one driver per excitation style, each driving a bench JK flip-flop.
module tb_jk_excite_drv;
  import jk_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       err_clr = 1'b0;
  logic       force_zero = 1'b0;
  logic [1:0] in_ready, J, K, busy, q_ff, q_fb;
`ifdef JK_EXCITE_DRV_CHECK_EN
  logic [1:0] err;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state (index 0 = set/reset style, 1 = toggle style)
  bit       mq[$];
  bit       m_qexp[2];
  bit [1:0] m_jk[2];
  bit       m_err[2];
  bit       m_pop1, m_pop2, m_b1, m_b2;

  always #5 clk = ~clk;

  assign q_fb = force_zero ? 2'b00 : q_ff;

  jk_excite_drv #(.DEPTH(DEPTH), .TOGGLE_STYLE(JK_STYLE_SR)) dut_sr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]), .in_bit(in_bit),
    .J(J[0]), .K(K[0]), .q_fb(q_fb[0]),
`ifdef JK_EXCITE_DRV_CHECK_EN
    .err_clr(err_clr), .err(err[0]),
`endif
    .busy(busy[0])
  );

  jk_excite_drv #(.DEPTH(DEPTH), .TOGGLE_STYLE(JK_STYLE_TGL)) dut_tg (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]), .in_bit(in_bit),
    .J(J[1]), .K(K[1]), .q_fb(q_fb[1]),
`ifdef JK_EXCITE_DRV_CHECK_EN
    .err_clr(err_clr), .err(err[1]),
`endif
    .busy(busy[1])
  );

  // Textbook JK flip-flop behaviour.
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    case ({j, k})
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_ff <= 2'b00;
    else for (int i = 0; i < 2; i++) q_ff[i] <= jk_next(q_ff[i], J[i], K[i]);
  end

  // Excitation table: hold when equal; set/reset or toggle otherwise.
  function automatic bit [1:0] spec_jk(input int style, input bit q, input bit b);
    if (q == b) return 2'b00;
    if (style == 1) return 2'b11;
    return b ? 2'b10 : 2'b01;
  endfunction

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int s = 0; s < 2; s++) begin
      m_qexp[s] = 1'b0;
      m_jk[s]   = 2'b00;
      m_err[s]  = 1'b0;
    end
    m_pop1 = 1'b0; m_pop2 = 1'b0; m_b1 = 1'b0; m_b2 = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    err_clr  = 1'b0;
    rst_n    = 1'b0;
    #1;
    model_reset();
    check("rst_jk_sr", {J[0], K[0]}, 2'b00);
    check("rst_jk_tg", {J[1], K[1]}, 2'b00);
    check("rst_busy", busy, 2'b00);
    check("rst_in_ready", in_ready, 2'b11);
`ifdef JK_EXCITE_DRV_CHECK_EN
    check("rst_err", err, 2'b00);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock edge with the given inputs, then compare every output against the model.
  task automatic step(input logic v, input logic b, input logic clr);
    logic [1:0] qfb_s;
    logic [1:0] exp_rdy, exp_busy;
    bit         pb;
    int         pre;
    in_valid = v;
    in_bit   = b;
    err_clr  = clr;
    #1;
    qfb_s = q_fb;
    @(posedge clk);
    for (int s = 0; s < 2; s++) begin
      if (clr) m_err[s] = 1'b0;
      else if (m_pop2 && (qfb_s[s] != m_b2)) m_err[s] = 1'b1;
    end
    m_pop2 = m_pop1;
    m_b2   = m_b1;
    pre    = mq.size();
    pb     = 1'b0;
    if (pre > 0) begin
      pb = mq.pop_front();
      for (int s = 0; s < 2; s++) begin
        m_jk[s]   = spec_jk(s, m_qexp[s], pb);
        m_qexp[s] = pb;
      end
    end else begin
      m_jk[0] = 2'b00;
      m_jk[1] = 2'b00;
    end
    m_pop1 = (pre > 0);
    m_b1   = pb;
    if (v && pre < DEPTH) mq.push_back(b);
    #1;
    exp_rdy = (mq.size() < DEPTH) ? 2'b11 : 2'b00;
`ifdef JK_EXCITE_DRV_CHECK_EN
    exp_busy = (mq.size() > 0 || m_pop1 || m_pop2) ? 2'b11 : 2'b00;
`else
    exp_busy = (mq.size() > 0) ? 2'b11 : 2'b00;
`endif
    check("jk_sr", {J[0], K[0]}, m_jk[0]);
    check("jk_tg", {J[1], K[1]}, m_jk[1]);
    check("in_ready", in_ready, exp_rdy);
    check("busy", busy, exp_busy);
`ifdef JK_EXCITE_DRV_CHECK_EN
    check("err", err, {m_err[1], m_err[0]});
`endif
  endtask

  initial begin
    // Set/reset style: push 1,1,0 from reset
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    check("sr_seq0_nobypass", {J[0], K[0]}, 2'b00);
    step(1'b1, 1'b1, 1'b0);
    check("sr_seq1", {J[0], K[0]}, 2'b10);
    step(1'b1, 1'b0, 1'b0);
    check("sr_seq2", {J[0], K[0]}, 2'b00);
    step(1'b0, 1'b0, 1'b0);
    check("sr_seq3", {J[0], K[0]}, 2'b01);
    step(1'b0, 1'b0, 1'b0);
    check("sr_seq4", {J[0], K[0]}, 2'b00);

    // Toggle style: push 1,0,0,1
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("tg_seq1", {J[1], K[1]}, 2'b11);
    step(1'b1, 1'b0, 1'b0);
    check("tg_seq2", {J[1], K[1]}, 2'b11);
    step(1'b1, 1'b1, 1'b0);
    check("tg_seq3", {J[1], K[1]}, 2'b00);
    step(1'b0, 1'b0, 1'b0);
    check("tg_seq4", {J[1], K[1]}, 2'b11);
    step(1'b0, 1'b0, 1'b0);

    // in_valid held high across pointer wrap; order checked by the model
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Reset mid-stream, then a fresh 1 encodes against q_exp=0
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("post_rst_sr", {J[0], K[0]}, 2'b10);
    check("post_rst_tg", {J[1], K[1]}, 2'b11);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Random stream with the flip-flops closing the loop
    do_reset();
    for (int i = 0; i < 140; i++)
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
`ifdef JK_EXCITE_DRV_CHECK_EN
    check("random_err_clean", err, 2'b00);

    // Feedback stuck at 0 while a 1 is issued
    do_reset();
    force_zero = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("err_before", err, 2'b00);
    step(1'b0, 1'b0, 1'b0);
    check("err_set", err, 2'b11);
    force_zero = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    check("err_sticky", err, 2'b11);
    step(1'b0, 1'b0, 1'b1);
    check("err_cleared", err, 2'b00);
    step(1'b0, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
